// File: rtl/mem_responder.sv
// mem_responder: MOV/RW/MOC memory responder with big-endian byte-addressed array and programmable latency
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LOAD   = 4'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

    logic              w_word;
    logic              w_half;
    logic              w_fire;
    logic [ADDR_W-1:0] w_a0;
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;
    logic [31:0]       w_rd;

    // Align the latched address for the access size and form the big-endian read value
    always_comb begin
        w_word = r_size[1];
        w_half = r_size == 2'b01;
        w_fire = r_state == S_WAIT && r_cnt == 4'd0 && MOV;
        w_a0   = w_word ? {r_addr[ADDR_W-1:2], 2'b00} : w_half ? {r_addr[ADDR_W-1:1], 1'b0} : r_addr;
        w_a1   = w_a0 + ADDR_W'(1);
        w_a2   = w_a0 + ADDR_W'(2);
        w_a3   = w_a0 + ADDR_W'(3);
        w_rd   = w_word ? {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]}
               : w_half ? {16'h0, r_mem[w_a0], r_mem[w_a1]}
               : {24'h0, r_mem[w_a0]};
    end

    // Handshake FSM: accept in IDLE, count down in WAIT, hold MOC in DONE until MOV drops
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_data  <= 32'h0;
            DataOut <= 32'h0;
            MOC     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (MOV) begin
                    r_rw    <= RW;
                    r_size  <= Size;
                    r_addr  <= Address;
                    r_data  <= DataIn;
                    r_cnt   <= LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (!MOV) begin
                    r_state <= S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_state <= S_DONE;
                    MOC     <= 1'b1;
                    if (r_rw) DataOut <= w_rd;
                end
                S_DONE: if (!MOV) begin
                    r_state <= S_IDLE;
                    MOC     <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    MOC     <= 1'b0;
                end
            endcase
        end
    end

    // Array write on the completing edge; only the addressed bytes change
    always_ff @(posedge Clk) begin
        if (w_fire && !r_rw) begin
            if (w_word) begin
                r_mem[w_a0] <= r_data[31:24];
                r_mem[w_a1] <= r_data[23:16];
                r_mem[w_a2] <= r_data[15:8];
                r_mem[w_a3] <= r_data[7:0];
            end else if (w_half) begin
                r_mem[w_a0] <= r_data[15:8];
                r_mem[w_a1] <= r_data[7:0];
            end else begin
                r_mem[w_a0] <= r_data[7:0];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder at LATENCY 2 and 1
module tb_mem_responder;
    logic        clk;
    logic        rst_n;
    logic        mov_a;
    logic        mov_b;
    logic        rw;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout_a;
    logic [31:0] dout_b;
    logic        moc_a;
    logic        moc_b;
    int          n_cmp;
    int          n_bad;

    mem_responder #(.ADDR_W(8), .LATENCY(2)) u_a (
        .Clk(clk), .Reset(rst_n), .MOV(mov_a), .RW(rw), .Size(size),
        .Address(addr), .DataIn(din), .DataOut(dout_a), .MOC(moc_a)
    );

    mem_responder #(.ADDR_W(8), .LATENCY(1)) u_b (
        .Clk(clk), .Reset(rst_n), .MOV(mov_b), .RW(rw), .Size(size),
        .Address(addr), .DataIn(din), .DataOut(dout_b), .MOC(moc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full handshake; request inputs are scrambled after accept to prove they are latched
    task automatic xfer(input bit sel, input logic r, input logic [1:0] sz, input logic [7:0] ad,
                        input logic [31:0] d, input int lat, input int hold, input string tag);
        int n;
        logic [31:0] prev;
        logic [31:0] snap;
        @(negedge clk);
        prev = sel ? dout_b : dout_a;
        rw   = r;
        size = sz;
        addr = ad;
        din  = d;
        if (sel) mov_b = 1'b1; else mov_a = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                rw   = ~r;
                size = ~sz;
                addr = ~ad;
                din  = ~d;
            end
        end while (!(sel ? moc_b : moc_a) && n < 20);
        check({tag, " lat"}, 32'(n), 32'(lat + 1));
        snap = sel ? dout_b : dout_a;
        check({tag, " data"}, snap, r ? d : prev);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold moc"}, {31'b0, sel ? moc_b : moc_a}, 32'd1);
            check({tag, " hold data"}, sel ? dout_b : dout_a, snap);
        end
        mov_a = 1'b0;
        mov_b = 1'b0;
        @(negedge clk);
        check({tag, " moc drop"}, {31'b0, sel ? moc_b : moc_a}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] prev;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        mov_a = 1'b0;
        mov_b = 1'b0;
        rw    = 1'b1;
        size  = 2'b00;
        addr  = 8'h00;
        din   = 32'h0;
        repeat (2) @(negedge clk);
        check("rst moc_a", {31'b0, moc_a}, 32'd0);
        check("rst dout_a", dout_a, 32'h0);
        check("rst moc_b", {31'b0, moc_b}, 32'd0);
        check("rst dout_b", dout_b, 32'h0);
        rst_n = 1'b1;

        xfer(0, 0, 2'b10, 8'h10, 32'hDEADBEEF, 2, 0, "wr w10");
        xfer(0, 1, 2'b10, 8'h10, 32'hDEADBEEF, 2, 3, "rd w10");
        xfer(0, 1, 2'b00, 8'h11, 32'h000000AD, 2, 0, "rd b11");
        xfer(0, 1, 2'b01, 8'h12, 32'h0000BEEF, 2, 0, "rd h12");
        xfer(0, 0, 2'b00, 8'h13, 32'h00000055, 2, 1, "wr b13");
        xfer(0, 1, 2'b10, 8'h12, 32'hDEADBE55, 2, 0, "rd w12");
        xfer(0, 1, 2'b01, 8'h10, 32'h0000DEAD, 2, 0, "rd h10");
        xfer(0, 1, 2'b00, 8'h12, 32'h000000BE, 2, 0, "rd b12");
        xfer(0, 0, 2'b10, 8'h20, 32'h0BADF00D, 2, 0, "wr w20");

        @(negedge clk);
        prev  = dout_a;
        rw    = 1'b0;
        size  = 2'b10;
        addr  = 8'h20;
        din   = 32'h12345678;
        mov_a = 1'b1;
        @(negedge clk);
        mov_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort moc", {31'b0, moc_a}, 32'd0);
        end
        check("abort dout", dout_a, prev);
        xfer(0, 1, 2'b10, 8'h20, 32'h0BADF00D, 2, 0, "rd w20 post abort");

        xfer(0, 0, 2'b01, 8'h23, 32'h00007788, 2, 0, "wr h23");
        xfer(0, 1, 2'b11, 8'h21, 32'h0BAD7788, 2, 0, "rd rsv21");

        xfer(0, 0, 2'b10, 8'hFE, 32'hA1B2C3D4, 2, 0, "wr wFE");
        xfer(0, 1, 2'b10, 8'hFC, 32'hA1B2C3D4, 2, 0, "rd wFC");
        xfer(0, 1, 2'b00, 8'hFF, 32'h000000D4, 2, 0, "rd bFF");
        xfer(0, 1, 2'b01, 8'hFE, 32'h0000C3D4, 2, 0, "rd hFE");

        xfer(1, 0, 2'b10, 8'hFE, 32'hA1B2C3D4, 1, 0, "L1 wr wFE");
        xfer(1, 1, 2'b10, 8'hFC, 32'hA1B2C3D4, 1, 2, "L1 rd wFC");
        xfer(1, 1, 2'b00, 8'hFC, 32'h000000A1, 1, 0, "L1 rd bFC");

        @(negedge clk);
        rw    = 1'b1;
        size  = 2'b10;
        addr  = 8'h10;
        mov_a = 1'b1;
        repeat (3) @(negedge clk);
        check("pre-rst moc", {31'b0, moc_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst moc", {31'b0, moc_a}, 32'd0);
        check("async rst dout", dout_a, 32'h0);
        @(negedge clk);
        check("in rst moc", {31'b0, moc_a}, 32'd0);
        #1 rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!moc_a && n < 20);
        check("post-rst lat", 32'(n), 32'd3);
        check("post-rst data", dout_a, 32'hDEADBE55);
        mov_a = 1'b0;
        @(negedge clk);
        check("post-rst moc drop", {31'b0, moc_a}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
